read_data_mux: RTL and testbench
================================

READ_DATA_MUX -- requirements
Module: read_data_mux

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of every read-data bus.
REQ-002 Parameter: DEC_BITS, 4, number of HADDR MSBs used for slave decode.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST  in  1  synchronous, active-high reset, sampled only on the rising CLK edge.
REQ-006 SEL  in  2  address-phase master grant: 01 is Master 1, 10 is Master 2, 00/11 means no master.
REQ-007 HADDR  in  32  address-phase address of the granted master.
REQ-008 HTRANS  in  2  address-phase transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 HRDATA_S1/S2/S3  in  DATA_WIDTH  slave read data.
REQ-010 HREADYOUT_S1/S2/S3  in  1  slave ready.
REQ-011 HRESP_S1/S2/S3  in  1  slave response: 0 OKAY, 1 ERROR.
REQ-012 HSEL_S  out  3  combinational one-hot address-phase slave select, with bit0 for S1.
REQ-013 HRDATA_1, HRDATA_2  out  DATA_WIDTH  read data returned to Master 1 and Master 2.
REQ-014 HREADY  out  1  shared bus ready.
REQ-015 HRESP  out  1  shared bus response.

Function
REQ-016 Decode is combinational on HADDR[31:32-DEC_BITS]: value 0 selects S1, 1 selects S2, 2 selects S3, and any other value selects the internal default slave (HSEL_S=000).
REQ-017 HSEL_S asserts only when HTRANS is NONSEQ/SEQ and SEL is 01 or 10; otherwise HSEL_S=000.
REQ-018 Two data-phase registers load on a rising edge when HREADY=1: dp_slave (S1/S2/S3/DEF/NONE) and dp_master (01/10/00). When HREADY=0 both registers hold.
REQ-019 dp_slave loads NONE when HTRANS is IDLE/BUSY or SEL is not 01/10; dp_master loads 00 in the same cases.
REQ-020 HRDATA/HREADY/HRESP routing is combinational from dp_slave: S1..S3 pass the selected slave's HRDATA, HREADYOUT and HRESP; for NONE, HREADY=1, HRESP=0 and data=0.
REQ-021 Routed data goes only to the master named by dp_master; the other HRDATA_x output drives 0. For dp_master=00, both outputs drive 0.
REQ-022 Read latency is one cycle after address-phase acceptance plus the slave's wait states; the mux adds no extra register stage on data.
REQ-023 The default-slave FSM has states IDLE, ERR1 and ERR2.
  - IDLE->ERR1 on an accepted address phase decoded DEF with HTRANS NONSEQ/SEQ.
  - ERR1: HREADY=0, HRESP=1; always goes to ERR2.
  - ERR2: HREADY=1, HRESP=1, data=0; goes to ERR1 if a new DEF NONSEQ/SEQ is accepted in this cycle, otherwise to IDLE.
REQ-024 When dp_slave=DEF with the FSM in IDLE (unreachable except after reset glitches), outputs are HREADY=1, HRESP=0, data=0.
REQ-025 Back-to-back: a new address phase accepted in the last data-phase cycle of a transfer takes effect on the next edge with no bubble, including a master switch from 01 to 10.
REQ-026 A SEL or HADDR change while HREADY=0 has no effect on dp_slave, dp_master or the FSM.
REQ-027 HRDATA outputs are never X; unselected or idle cases drive all-zero.

Reset
REQ-028 While RST=1 at a rising edge, the next state is: dp_slave=NONE, dp_master=00, FSM=IDLE.
REQ-029 The resulting outputs after reset are HREADY=1, HRESP=0, HRDATA_1=HRDATA_2=0; HSEL_S follows its inputs combinationally.
REQ-030 Reset asserted mid-transfer (slave wait or ERR1) aborts the transfer; the stall is released at the next edge.

Verification
REQ-031 M1 read S2: SEL=01, HADDR=0x1000_0004, HTRANS=10, HRDATA_S2=0xCAFE_F00D, HREADYOUT_S2=1 -> HSEL_S=010; next cycle HRDATA_1=0xCAFE_F00D, HRDATA_2=0, HREADY=1.
REQ-032 Wait states: M2 read S3, HREADYOUT_S3 low for 2 cycles -> HREADY=0 for 2 cycles, dp registers hold despite SEL/HADDR changes, and data appears on HRDATA_2 in cycle 3.
REQ-033 Unmapped read: HADDR=0x7000_0000, NONSEQ -> HSEL_S=000; ERR1 gives HREADY=0/HRESP=1, then ERR2 gives HREADY=1/HRESP=1, then IDLE gives HRESP=0.
REQ-034 Back-to-back switch: M1 read S1 followed immediately by M2 read S2 -> HRDATA_1 carries S1 data, then HRDATA_2 carries S2 data on consecutive cycles with no idle cycle.
REQ-035 Reset in ERR1: assert RST one cycle -> next edge gives HREADY=1, HRESP=0 and both HRDATA outputs 0.
REQ-036 IDLE transfer: HTRANS=00 with SEL=01 -> HSEL_S=000; next cycle HREADY=1, HRESP=0, HRDATA_1=0.

Source files
------------

// File: rtl/read_data_mux.sv
// Read-data and response multiplexer for a two-master, three-slave bus.
// Ports: CLK, RST, SEL, HADDR, HTRANS and per-slave HRDATA/HREADYOUT/HRESP
// go in; HSEL_S, HRDATA_1, HRDATA_2, HREADY and HRESP come out.
module read_data_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int DEC_BITS   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            SEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HRDATA_S1,
    input  logic [DATA_WIDTH-1:0] HRDATA_S2,
    input  logic [DATA_WIDTH-1:0] HRDATA_S3,
    input  logic                  HREADYOUT_S1,
    input  logic                  HREADYOUT_S2,
    input  logic                  HREADYOUT_S3,
    input  logic                  HRESP_S1,
    input  logic                  HRESP_S2,
    input  logic                  HRESP_S3,
    output logic [2:0]            HSEL_S,
    output logic [DATA_WIDTH-1:0] HRDATA_1,
    output logic [DATA_WIDTH-1:0] HRDATA_2,
    output logic                  HREADY,
    output logic                  HRESP
);

    typedef enum logic [2:0] {
        SL_NONE,
        SL_S1,
        SL_S2,
        SL_S3,
        SL_DEF
    } slave_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    slave_e dp_slave_q, dp_slave_d;
    logic [1:0] dp_master_q, dp_master_d;
    state_e state_q, state_d;

    logic [DEC_BITS-1:0] dec;
    slave_e a_slave;
    logic a_valid;
    logic [DATA_WIDTH-1:0] rdata;

    // Low address bits play no part in the slave decode.
    logic unused_addr;
    assign unused_addr = ^HADDR[31-DEC_BITS:0];

    assign dec = HADDR[31:32-DEC_BITS];
    assign a_valid = HTRANS[1] & ((SEL == 2'b01) | (SEL == 2'b10));

    always_comb begin
        a_slave = SL_DEF;
        if (dec == DEC_BITS'(0)) begin
            a_slave = SL_S1;
        end else if (dec == DEC_BITS'(1)) begin
            a_slave = SL_S2;
        end else if (dec == DEC_BITS'(2)) begin
            a_slave = SL_S3;
        end
    end

    always_comb begin
        HSEL_S = 3'b000;
        if (a_valid) begin
            case (a_slave)
                SL_S1:   HSEL_S = 3'b001;
                SL_S2:   HSEL_S = 3'b010;
                SL_S3:   HSEL_S = 3'b100;
                default: HSEL_S = 3'b000;
            endcase
        end
    end

    // Data-phase routing. A DEF data phase with the FSM idle can only
    // follow a reset glitch; it completes as a plain OKAY.
    always_comb begin
        rdata  = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (dp_slave_q)
            SL_S1: begin
                rdata  = HRDATA_S1;
                HREADY = HREADYOUT_S1;
                HRESP  = HRESP_S1;
            end
            SL_S2: begin
                rdata  = HRDATA_S2;
                HREADY = HREADYOUT_S2;
                HRESP  = HRESP_S2;
            end
            SL_S3: begin
                rdata  = HRDATA_S3;
                HREADY = HREADYOUT_S3;
                HRESP  = HRESP_S3;
            end
            SL_DEF: begin
                case (state_q)
                    ST_ERR1: begin
                        HREADY = 1'b0;
                        HRESP  = 1'b1;
                    end
                    ST_ERR2: begin
                        HREADY = 1'b1;
                        HRESP  = 1'b1;
                    end
                    default: begin
                        HREADY = 1'b1;
                        HRESP  = 1'b0;
                    end
                endcase
            end
            default: begin
                rdata  = '0;
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
        endcase
    end

    assign HRDATA_1 = (dp_master_q == 2'b01) ? rdata : '0;
    assign HRDATA_2 = (dp_master_q == 2'b10) ? rdata : '0;

    always_comb begin
        dp_slave_d  = dp_slave_q;
        dp_master_d = dp_master_q;
        if (HREADY) begin
            if (a_valid) begin
                dp_slave_d  = a_slave;
                dp_master_d = SEL;
            end else begin
                dp_slave_d  = SL_NONE;
                dp_master_d = 2'b00;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (HREADY && a_valid && a_slave == SL_DEF) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: begin
                if (HREADY && a_valid && a_slave == SL_DEF) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dp_slave_q  <= SL_NONE;
            dp_master_q <= 2'b00;
            state_q     <= ST_IDLE;
        end else begin
            dp_slave_q  <= dp_slave_d;
            dp_master_q <= dp_master_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_read_data_mux.sv
// Self-checking bench for read_data_mux: directed scenarios plus
// randomized traffic compared against a transfer-level reference model.
module tb_read_data_mux;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  SEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic        HRESP_S1, HRESP_S2, HRESP_S3;
    logic [2:0]  HSEL_S;
    logic [31:0] HRDATA_1, HRDATA_2;
    logic        HREADY, HRESP;

    int checks = 0;
    int errors = 0;

    read_data_mux #(.DATA_WIDTH(32), .DEC_BITS(4)) dut (
        .CLK(CLK), .RST(RST), .SEL(SEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_S1(HREADYOUT_S1), .HREADYOUT_S2(HREADYOUT_S2),
        .HREADYOUT_S3(HREADYOUT_S3),
        .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
        .HSEL_S(HSEL_S), .HRDATA_1(HRDATA_1), .HRDATA_2(HRDATA_2),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 CLK = ~CLK;

    // Reference model: target of the outstanding data phase
    // (0 none, 1..3 slave, 4 unmapped), its master, and how many
    // error-response cycles remain (2 = stall cycle, 1 = completing cycle).
    int         m_tgt = 0;
    logic [1:0] m_mst = 2'b00;
    int         m_err = 0;

    logic [2:0]  e_hsel;
    logic        e_rdy, e_resp, e_valid;
    logic [31:0] e_data, e_d1, e_d2;
    int          e_nib;

    always_comb begin
        e_nib   = int'(HADDR[31:28]);
        e_valid = (HTRANS >= 2'd2) && (SEL == 2'd1 || SEL == 2'd2);
        e_hsel  = 3'b000;
        if (e_valid && e_nib < 3) e_hsel = 3'(1 << e_nib);
        e_rdy  = 1'b1;
        e_resp = 1'b0;
        e_data = 32'h0;
        if (m_tgt == 1) begin
            e_rdy = HREADYOUT_S1; e_resp = HRESP_S1; e_data = HRDATA_S1;
        end else if (m_tgt == 2) begin
            e_rdy = HREADYOUT_S2; e_resp = HRESP_S2; e_data = HRDATA_S2;
        end else if (m_tgt == 3) begin
            e_rdy = HREADYOUT_S3; e_resp = HRESP_S3; e_data = HRDATA_S3;
        end else if (m_tgt == 4) begin
            e_rdy  = (m_err != 2);
            e_resp = (m_err > 0);
        end
        e_d1 = (m_mst == 2'd1) ? e_data : 32'h0;
        e_d2 = (m_mst == 2'd2) ? e_data : 32'h0;
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_tgt <= 0; m_mst <= 2'b00; m_err <= 0;
        end else if (e_rdy) begin
            if (e_valid) begin
                m_tgt <= (e_nib < 3) ? e_nib + 1 : 4;
                m_mst <= SEL;
                m_err <= (e_nib < 3) ? 0 : 2;
            end else begin
                m_tgt <= 0; m_mst <= 2'b00; m_err <= 0;
            end
        end else if (m_err == 2) begin
            m_err <= 1;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        SEL = 2'b00; HADDR = 32'h0; HTRANS = 2'b00;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_in();
        HRDATA_S1 = 32'h1111_1111; HRDATA_S2 = 32'h2222_2222;
        HRDATA_S3 = 32'h3333_3333;
        HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1; HREADYOUT_S3 = 1'b1;
        HRESP_S1 = 1'b0; HRESP_S2 = 1'b0; HRESP_S3 = 1'b0;
        cyc();
        cyc();
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_resp got %b/%b exp 1/0", HREADY, HRESP);
        end
        checks++;
        if (HRDATA_1 !== 32'h0 || HRDATA_2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h exp 0/0", HRDATA_1, HRDATA_2);
        end
        cyc();
        RST = 1'b0;
    endtask

    task automatic test_m1_read_s2();
        cyc();
        SEL = 2'b01; HADDR = 32'h1000_0004; HTRANS = 2'b10;
        HRDATA_S2 = 32'hCAFE_F00D; HREADYOUT_S2 = 1'b1;
        @(negedge CLK);
        checks++;
        if (HSEL_S !== 3'b010) begin
            errors++;
            $display("FAIL m1s2_hsel got %b exp 010", HSEL_S);
        end
        cyc();
        idle_in();
        @(negedge CLK);
        checks++;
        if (HRDATA_1 !== 32'hCAFE_F00D || HRDATA_2 !== 32'h0 || HREADY !== 1'b1) begin
            errors++;
            $display("FAIL m1s2_data got %h/%h/%b exp cafef00d/0/1",
                     HRDATA_1, HRDATA_2, HREADY);
        end
    endtask

    task automatic test_wait_states();
        cyc();
        SEL = 2'b10; HADDR = 32'h2000_0000; HTRANS = 2'b10;
        HRDATA_S3 = 32'h3333_0001;
        @(negedge CLK);
        checks++;
        if (HSEL_S !== 3'b100) begin
            errors++;
            $display("FAIL ws_hsel got %b exp 100", HSEL_S);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            HREADYOUT_S3 = 1'b0;
            SEL = 2'b01; HTRANS = 2'b10;
            HADDR = (i == 0) ? 32'h1000_0000 : 32'h7000_0000;
            @(negedge CLK);
            checks++;
            if (HREADY !== 1'b0) begin
                errors++;
                $display("FAIL ws_stall%0d got %b exp 0", i, HREADY);
            end
        end
        cyc();
        HREADYOUT_S3 = 1'b1;
        idle_in();
        @(negedge CLK);
        checks++;
        if (HRDATA_2 !== 32'h3333_0001 || HRDATA_1 !== 32'h0 ||
            HREADY !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL ws_done got %h/%h/%b/%b exp 33330001/0/1/0",
                     HRDATA_2, HRDATA_1, HREADY, HRESP);
        end
    endtask

    task automatic test_unmapped();
        cyc();
        SEL = 2'b01; HADDR = 32'h7000_0000; HTRANS = 2'b10;
        @(negedge CLK);
        checks++;
        if (HSEL_S !== 3'b000) begin
            errors++;
            $display("FAIL um_hsel got %b exp 000", HSEL_S);
        end
        cyc();
        idle_in();
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b0 || HRESP !== 1'b1) begin
            errors++;
            $display("FAIL um_err1 got %b/%b exp 0/1", HREADY, HRESP);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b1 || HRDATA_1 !== 32'h0) begin
            errors++;
            $display("FAIL um_err2 got %b/%b/%h exp 1/1/0", HREADY, HRESP, HRDATA_1);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL um_idle got %b/%b exp 1/0", HREADY, HRESP);
        end
    endtask

    task automatic test_back_to_back();
        cyc();
        SEL = 2'b01; HADDR = 32'h0000_0010; HTRANS = 2'b10;
        HRDATA_S1 = 32'hA1A1_0001; HRDATA_S2 = 32'hB2B2_0002;
        cyc();
        SEL = 2'b10; HADDR = 32'h1000_0020; HTRANS = 2'b11;
        @(negedge CLK);
        checks++;
        if (HRDATA_1 !== 32'hA1A1_0001 || HRDATA_2 !== 32'h0 || HREADY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got %h/%h/%b exp a1a10001/0/1",
                     HRDATA_1, HRDATA_2, HREADY);
        end
        cyc();
        idle_in();
        @(negedge CLK);
        checks++;
        if (HRDATA_2 !== 32'hB2B2_0002 || HRDATA_1 !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got %h/%h exp b2b20002/0", HRDATA_2, HRDATA_1);
        end
    endtask

    task automatic test_reset_in_err1();
        cyc();
        SEL = 2'b10; HADDR = 32'hF000_0000; HTRANS = 2'b10;
        cyc();
        idle_in();
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b0) begin
            errors++;
            $display("FAIL rst_err1_pre got %b exp 0", HREADY);
        end
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0 ||
            HRDATA_1 !== 32'h0 || HRDATA_2 !== 32'h0) begin
            errors++;
            $display("FAIL rst_err1 got %b/%b/%h/%h exp 1/0/0/0",
                     HREADY, HRESP, HRDATA_1, HRDATA_2);
        end
    endtask

    task automatic test_idle_transfer();
        cyc();
        SEL = 2'b01; HADDR = 32'h0000_0000; HTRANS = 2'b00;
        HRDATA_S1 = 32'h5555_AAAA;
        @(negedge CLK);
        checks++;
        if (HSEL_S !== 3'b000) begin
            errors++;
            $display("FAIL idle_hsel got %b exp 000", HSEL_S);
        end
        cyc();
        idle_in();
        @(negedge CLK);
        checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA_1 !== 32'h0) begin
            errors++;
            $display("FAIL idle_data got %b/%b/%h exp 1/0/0", HREADY, HRESP, HRDATA_1);
        end
    endtask

    task automatic test_random();
        logic [31:0] nib;
        for (int i = 0; i < 400; i++) begin
            cyc();
            RST = ($urandom_range(0, 39) == 0);
            SEL = 2'($urandom_range(0, 3));
            HTRANS = 2'($urandom_range(0, 3));
            nib = $urandom_range(0, 5);
            if (nib > 3) nib = $urandom_range(3, 15);
            HADDR = {nib[3:0], 28'($urandom)};
            HRDATA_S1 = $urandom; HRDATA_S2 = $urandom; HRDATA_S3 = $urandom;
            HREADYOUT_S1 = ($urandom_range(0, 3) != 0);
            HREADYOUT_S2 = ($urandom_range(0, 3) != 0);
            HREADYOUT_S3 = ($urandom_range(0, 3) != 0);
            HRESP_S1 = ($urandom_range(0, 7) == 0);
            HRESP_S2 = ($urandom_range(0, 7) == 0);
            HRESP_S3 = ($urandom_range(0, 7) == 0);
            @(negedge CLK);
            checks++;
            if (HSEL_S !== e_hsel) begin
                errors++;
                $display("FAIL rnd_hsel[%0d] got %b exp %b", i, HSEL_S, e_hsel);
            end
            checks++;
            if (HREADY !== e_rdy || HRESP !== e_resp) begin
                errors++;
                $display("FAIL rnd_rdy_resp[%0d] got %b/%b exp %b/%b",
                         i, HREADY, HRESP, e_rdy, e_resp);
            end
            checks++;
            if (HRDATA_1 !== e_d1 || HRDATA_2 !== e_d2) begin
                errors++;
                $display("FAIL rnd_data[%0d] got %h/%h exp %h/%h",
                         i, HRDATA_1, HRDATA_2, e_d1, e_d2);
            end
        end
        cyc();
        RST = 1'b0;
        idle_in();
    endtask

    initial begin
        RST = 1'b1;
        idle_in();
        test_reset();
        test_m1_read_s2();
        test_wait_states();
        test_unmapped();
        test_back_to_back();
        test_reset_in_err1();
        test_idle_transfer();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
